bit_population_generator: RTL and testbench
===========================================

BIT_POPULATION_GENERATOR -- requirements
Module: bit_population_generator

Interface
REQ-001 Parameter: WIDTH, default 16, data word width in bits; legal range 2..32.
REQ-002 clk_i  input  1  sole clock; all logic on posedge.
REQ-003 srst_i  input  1  reset, synchronous, active-high.
REQ-004 count_i  input  $clog2(WIDTH)+1  requested population count k.
REQ-005 count_val_i  input  1  count_i valid.
REQ-006 count_ready_o  output  1  block idle and able to accept a count.
REQ-007 data_o  output  WIDTH  generated word with exactly k bits set.
REQ-008 data_val_o  output  1  data_o valid.
REQ-009 data_last_o  output  1  data_o is the final word for the current k.
REQ-010 data_ready_i  input  1  downstream accepts data_o.
REQ-011 err_o  output  1  one-cycle pulse: accepted k exceeds WIDTH.

Function
REQ-012 The block SHALL enumerate every WIDTH-bit word whose popcount equals k, each exactly once, in strictly ascending unsigned order, i.e. C(WIDTH,k) words per request.
REQ-013 The block SHALL have states IDLE and RUN; count_ready_o SHALL be 1 in IDLE and 0 in RUN.
REQ-014 A count is accepted on a cycle where count_val_i=1 and count_ready_o=1; count_val_i in RUN SHALL be ignored.
REQ-015 On acceptance with 0<=k<=WIDTH at cycle t, the block SHALL enter RUN and present the first word ((1<<k)-1) with data_val_o=1 at cycle t+1.
REQ-016 The final word SHALL be k ones in the top k bit positions; data_last_o SHALL be 1 exactly while that word is presented.
REQ-017 k=0 SHALL produce one word, all zeros, with data_last_o=1; k=WIDTH SHALL produce one word, all ones, with data_last_o=1.
REQ-018 A word transfers on a cycle with data_val_o=1 and data_ready_i=1; after a non-last transfer the successor word SHALL appear on the next cycle with data_val_o held 1 (throughput one word per cycle).
REQ-019 While data_val_o=1 and data_ready_i=0, data_o, data_val_o and data_last_o SHALL remain stable.
REQ-020 Successor computation SHALL be the next-combination rule: isolate lowest set bit c, r=x+c, next = r | (((r^x)>>2) >> ctz(c)), evaluated in WIDTH-bit arithmetic; no divider.
REQ-021 After the last-word transfer the block SHALL return to IDLE, drive data_val_o=0 and data_last_o=0, and assert count_ready_o on the next cycle.
REQ-022 On acceptance with k>WIDTH the block SHALL stay in IDLE, pulse err_o for exactly the following cycle, and emit no words.
REQ-023 data_o SHALL be driven from a register; data_o value while data_val_o=0 is don't-care.
REQ-024 Successor logic SHALL complete within one clock; no multi-cycle paths.

Reset
REQ-025 While srst_i=1 on a clock edge: state=IDLE, data_val_o=0, data_last_o=0, err_o=0, data_o=0; count_ready_o=1 from the first cycle after reset deasserts.
REQ-026 Reset during RUN SHALL abandon the sequence with no further words; the next request starts from its first word.
REQ-027 srst_i SHALL take priority over every concurrent handshake on the same edge.

Verification
REQ-028 WIDTH=4, k=2, data_ready_i=1 -> words 0011,0101,0110,1001,1010,1100 on six consecutive cycles starting t+1, data_last_o only on 1100, count_ready_o=1 at t+7.
REQ-029 WIDTH=4, k=0 -> single word 0000 with data_last_o=1; k=4 -> single word 1111 with data_last_o=1.
REQ-030 WIDTH=4, k=5 -> err_o=1 for one cycle at t+1, data_val_o stays 0, count_ready_o stays 1.
REQ-031 WIDTH=4, k=2, data_ready_i=0 for 3 cycles at second word -> 0101 held stable 3 cycles, then sequence resumes unchanged, no word lost or duplicated.
REQ-032 WIDTH=16, k=8, srst_i pulsed after 10 transfers; count_val_i pulsed with k=3 mid-run before reset -> k=3 ignored; after reset data_val_o=0, then new k=1 yields 0x0001 first, 0x8000 last, 16 words total.
REQ-033 Random k in 0..WIDTH with random data_ready_i -> scoreboard checks popcount of every word equals k, strictly ascending order, count equals C(WIDTH,k).

Source files
------------

// File: rtl/bit_population_generator.sv
// -----------------------------------------------------------------------------
// bit_population_generator
//
// Purpose:
//   On request, enumerates every WIDTH-bit word with exactly k bits set, in
//   strictly ascending unsigned order, one word per cycle while the consumer
//   is ready. A request with k > WIDTH is rejected with a one-cycle err pulse.
//
// Handshakes (both sides use the same valid/ready rule):
//   A beat transfers on a rising clk edge where valid=1 and ready=1. A
//   producer holding valid=1 keeps its payload stable until that transfer;
//   ready may be driven independently of valid.
//
// Ports:
//   clk_i          sole clock, all logic on posedge
//   srst_i         synchronous active-high reset, beats every handshake
//   count_i        requested population count k
//   count_val_i    count_i valid
//   count_ready_o  1 in IDLE (request accepted), 0 in RUN
//   data_o         registered word with exactly k bits set
//   data_val_o     data_o valid
//   data_last_o    data_o is the final (top-aligned) word for this k
//   data_ready_i   downstream accepts data_o
//   err_o          one-cycle pulse after accepting k > WIDTH
//   fsm_state      debug view of the FSM (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module bit_population_generator #(
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [$clog2(WIDTH):0]   count_i,
  input  logic                     count_val_i,
  output logic                     count_ready_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     data_val_o,
  output logic                     data_last_o,
  input  logic                     data_ready_i,
  output logic                     err_o,
  output logic                     fsm_state
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam logic [KW-1:0]    K_MAX = KW'(WIDTH);
  localparam logic [WIDTH-1:0] ONES  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] last_word_q;

  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] top_word;
  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] ripple;
  logic [WIDTH-1:0] succ;
  logic [KW-1:0]    tz;

  // Shifting the all-ones pattern avoids a WIDTH+1-bit (1<<k)-1 when k=WIDTH;
  // a shift by WIDTH yields zero, so both ends fall out naturally.
  assign first_word = ~(ONES << count_i);
  assign top_word   = ~(ONES >> count_i);

  // Next-combination successor: the lowest set bit ripples up one position
  // and the ones it clears are re-packed at the bottom of the word.
  always_comb begin
    low_bit = data_o & (~data_o + WIDTH'(1));
    ripple  = data_o + low_bit;
    tz      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (low_bit[i]) tz = KW'(i);
    end
    succ = ripple | (((ripple ^ data_o) >> 2) >> tz);
  end

  assign count_ready_o = (state_q == IDLE);
  assign fsm_state     = state_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= IDLE;
      data_o      <= '0;
      data_val_o  <= 1'b0;
      data_last_o <= 1'b0;
      err_o       <= 1'b0;
      last_word_q <= '0;
    end else begin
      err_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (count_val_i) begin
            if (count_i > K_MAX) begin
              err_o <= 1'b1;
            end else begin
              state_q     <= RUN;
              data_o      <= first_word;
              last_word_q <= top_word;
              data_val_o  <= 1'b1;
              // Only k=0 and k=WIDTH have a single-word sequence.
              data_last_o <= (first_word == top_word);
            end
          end
        end
        RUN: begin
          if (data_ready_i) begin
            if (data_last_o) begin
              state_q     <= IDLE;
              data_val_o  <= 1'b0;
              data_last_o <= 1'b0;
            end else begin
              data_o      <= succ;
              data_last_o <= (succ == last_word_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_population_generator.sv
module tb_bit_population_generator;

  logic clk;
  logic srst;

  // WIDTH=4 instance
  logic [2:0]  a_k;
  logic        a_cval, a_cready, a_dval, a_last, a_rdy, a_err, a_fsm;
  logic [3:0]  a_data;

  // WIDTH=16 instance
  logic [4:0]  b_k;
  logic        b_cval, b_cready, b_dval, b_last, b_rdy, b_err, b_fsm;
  logic [15:0] b_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit_population_generator #(.WIDTH(4)) u_w4 (
    .clk_i(clk), .srst_i(srst), .count_i(a_k), .count_val_i(a_cval),
    .count_ready_o(a_cready), .data_o(a_data), .data_val_o(a_dval),
    .data_last_o(a_last), .data_ready_i(a_rdy), .err_o(a_err),
    .fsm_state(a_fsm)
  );

  bit_population_generator #(.WIDTH(16)) u_w16 (
    .clk_i(clk), .srst_i(srst), .count_i(b_k), .count_val_i(b_cval),
    .count_ready_o(b_cready), .data_o(b_data), .data_val_o(b_dval),
    .data_last_o(b_last), .data_ready_i(b_rdy), .err_o(b_err),
    .fsm_state(b_fsm)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Smallest value above prev with popcount k (brute-force search).
  function automatic logic [15:0] next_pop(input logic [15:0] prev, input int k);
    for (int v = int'(prev) + 1; v < 65536; v++) begin
      logic [15:0] t;
      t = v[15:0];
      if ($countones(t) == k) return t;
    end
    return 16'h0;
  endfunction

  // ---------------- drivers ----------------
  task automatic a_request(input logic [2:0] k);
    chk("a_ready_before_req", a_cready, 1);
    a_k = k; a_cval = 1'b1;
    @(negedge clk);
    a_cval = 1'b0;
  endtask

  task automatic b_request(input logic [4:0] k);
    chk("b_ready_before_req", b_cready, 1);
    b_k = k; b_cval = 1'b1;
    @(negedge clk);
    b_cval = 1'b0;
  endtask

  // Consumes exp_q with data_ready held high, one word per cycle.
  task automatic a_drain(input string tag);
    int n;
    n = exp_q.size();
    a_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_val"},  a_dval, 1);
      chk({tag, "_data"}, a_data, exp_q[0]);
      chk({tag, "_last"}, a_last, (exp_q.size() == 1));
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    chk({tag, "_ready_after"}, a_cready, 1);
    chk({tag, "_val_after"},   a_dval, 0);
    chk({tag, "_last_after"},  a_last, 0);
  endtask

  task automatic b_drain(input string tag);
    int n;
    n = exp_q.size();
    b_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_val"},  b_dval, 1);
      chk({tag, "_data"}, b_data, exp_q[0]);
      chk({tag, "_last"}, b_last, (exp_q.size() == 1));
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    chk({tag, "_ready_after"}, b_cready, 1);
    chk({tag, "_val_after"},   b_dval, 0);
  endtask

  // Random ready; scoreboard checks popcount, ordering, last flag and count.
  task automatic a_random(input int k);
    int cnt, cyc;
    logic [3:0] prev;
    bit done;
    cnt = 0; cyc = 0; done = 0; prev = '0;
    a_request(3'(k));
    while (!done && cyc < 200) begin
      a_rdy = 1'($urandom_range(0, 1));
      if (a_dval && a_rdy) begin
        chk("rnd_popcount", $countones(a_data), k);
        if (cnt > 0) chk("rnd_ascending", (a_data > prev), 1);
        chk("rnd_last", a_last, (cnt + 1 == binom(4, k)));
        prev = a_data;
        cnt++;
        if (a_last) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rnd_done_in_budget", done, 1);
    chk("rnd_word_count", cnt, binom(4, k));
    chk("rnd_ready_after", a_cready, 1);
    a_rdy = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] w;
    srst = 1'b1;
    a_k = '0; a_cval = 1'b0; a_rdy = 1'b1;
    b_k = '0; b_cval = 1'b0; b_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a_val",  a_dval, 0);
    chk("rst_a_last", a_last, 0);
    chk("rst_a_err",  a_err, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_val",  b_dval, 0);
    chk("rst_b_data", b_data, 0);
    srst = 1'b0;
    @(negedge clk);
    chk("rst_a_ready", a_cready, 1);
    chk("rst_b_ready", b_cready, 1);
    chk("rst_a_fsm",   a_fsm, 0);

    // k=2 on 4 bits, free-running consumer
    a_request(3'd2);
    chk("k2_fsm_run", a_fsm, 1);
    chk("k2_ready_low", a_cready, 0);
    exp_q = '{16'h3, 16'h5, 16'h6, 16'h9, 16'hA, 16'hC};
    a_drain("k2");

    // single-word sequences
    a_request(3'd0);
    exp_q = '{16'h0};
    a_drain("k0");
    a_request(3'd4);
    exp_q = '{16'hF};
    a_drain("k4");

    // k above WIDTH: err pulse only
    a_request(3'd5);
    chk("k5_err",   a_err, 1);
    chk("k5_val",   a_dval, 0);
    chk("k5_ready", a_cready, 1);
    @(negedge clk);
    chk("k5_err_clear", a_err, 0);
    chk("k5_val_idle",  a_dval, 0);
    chk("k5_ready2",    a_cready, 1);

    // back-pressure on the second word
    a_request(3'd2);
    chk("stall_first", a_data, 4'h3);
    @(negedge clk);
    chk("stall_second", a_data, 4'h5);
    a_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_data", a_data, 4'h5);
      chk("stall_hold_val",  a_dval, 1);
      chk("stall_hold_last", a_last, 0);
    end
    exp_q = '{16'h5, 16'h6, 16'h9, 16'hA, 16'hC};
    a_drain("stall_resume");

    // 16 bits, k=8: reset mid-run, ignored request during RUN
    b_rdy = 1'b1;
    b_request(5'd8);
    w = 16'h00FF;
    for (int i = 0; i < 10; i++) begin
      chk("k8_data", b_data, w);
      chk("k8_val",  b_dval, 1);
      if (i == 4) begin
        b_k = 5'd3; b_cval = 1'b1;
      end else begin
        b_cval = 1'b0;
      end
      w = next_pop(w, 8);
      @(negedge clk);
    end
    b_cval = 1'b0;
    chk("k8_eleventh", b_data, w);
    chk("k8_ready_low", b_cready, 0);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("k8_rst_val",  b_dval, 0);
    chk("k8_rst_last", b_last, 0);
    chk("k8_rst_data", b_data, 0);
    chk("k8_rst_fsm",  b_fsm, 0);
    @(negedge clk);
    chk("k8_rst_ready", b_cready, 1);
    chk("k8_rst_val2",  b_dval, 0);
    b_request(5'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h1 << i);
    b_drain("k1");

    // random requests with random back-pressure
    for (int r = 0; r < 12; r++) begin
      a_random($urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
